bit_serial_adder: RTL and testbench

- Multi-cycle, bit-serial adder for two WIDTH-bit operands plus a carry-in.
- Each cycle it consumes one bit pair, LSB first, through a single instance of the team's existing full-adder cell (fa_using_ha). A carry flip-flop feeds that cell's cin.
- Sits directly downstream of the full-adder cell and turns it into a word-level adder with a start/done handshake, for area-constrained datapaths.

---
 rtl/bit_serial_pkg.sv | 14 +
 rtl/fa_using_ha.sv | 33 +++
 rtl/half_adder.sv | 15 +
 rtl/bit_serial_adder.sv | 123 ++++++++++++
 tb/tb_bit_serial_adder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder.
//   DEFAULT_WIDTH : default operand/sum width in bits
//   state_t       : controller state encoding (binary); 2'd3 is unreachable
package bit_serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_using_ha.sv
// Full adder built from two half adders.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   carry     : majority(a, b, cin)
module fa_using_ha (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s1),
        .carry (c1)
    );

    half_adder u_ha1 (
        .a     (s1),
        .b     (cin),
        .sum   (sum),
        .carry (c2)
    );

    assign carry = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Half adder cell.
//   a, b  : input bits
//   sum   : a ^ b
//   carry : a & b
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// Word-level adder that evaluates one bit pair per cycle, LSB first, through a
// single full-adder cell, with a start/done handshake.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   start   : request, sampled only while idle
//   a_in    : operand A, captured on the accepting edge
//   b_in    : operand B, captured on the accepting edge
//   cin_in  : carry-in, captured on the accepting edge
//   busy    : high while the operation is running
//   done    : one-cycle pulse; sum_out/cout valid from this cycle onwards
//   sum_out : result register
//   cout    : final carry-out
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH:0]   sum_cat;
    logic [WIDTH-1:0] sum_next;

    fa_using_ha u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New bit enters at the MSB and the word shifts right, so the first bit
    // computed lands at bit 0 after WIDTH shifts. Built by concatenation so
    // WIDTH=1 needs no empty slice.
    assign sum_cat  = {fa_sum, sum_sr};
    assign sum_next = sum_cat[WIDTH:1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the unused encoding falls back to idle
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_next = (cnt == LAST) ? ST_DONE : ST_RUN;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand shift registers, carry FF, counter, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin_in;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_sr <= sum_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_carry;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum_out <= sum_next;
                        cout    <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: an 8-bit instance exercised with
// directed vectors, multi-cycle corner sequences and randomized back-to-back
// operations, plus a 1-bit instance checked exhaustively.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

    int n_chk;
    int n_fail;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin_in  (cin_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .a_in    (a1),
        .b_in    (b1),
        .cin_in  (cin1),
        .busy    (busy1),
        .done    (done1),
        .sum_out (sum1),
        .cout    (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           acc;
    } op_t;

    // One full operation on the 8-bit instance with latency/busy/pulse checks.
    task automatic run8(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec);
        int lat;
        int nbusy;
        @(negedge clk);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = c;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cin_in = 1'($urandom);
        lat    = 0;
        nbusy  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) nbusy++;
        end
        chk({name, "_latency"}, lat, W);
        chk({name, "_busy_cycles"}, nbusy, W);
        chk({name, "_sum"}, sum_out, es);
        chk({name, "_cout"}, cout, ec);
        @(posedge clk);
        #1;
        chk({name, "_done_single"}, done, 0);
        chk({name, "_sum_hold"}, sum_out, es);
    endtask

    initial begin
        vec_t vecs[$];
        op_t  q[$];
        op_t  o;
        int   e;
        int   next_acc;
        int   last_done;
        int   ops;
        int   cyc;
        int   ndone;
        logic exp_done;
        logic [W:0] ref_sum;
        logic [1:0] ref1;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_sum1", {cout1, sum1}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        vecs.push_back('{"v_3c_0f",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0});
        vecs.push_back('{"v_ripple",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"v_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{"v_zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{"v_cin_only",8'h00, 8'h00, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{"v_80_80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"v_a5_5a_1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1});
        for (int i = 0; i < vecs.size(); i++) begin
            run8(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin,
                 vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // start pulses during RUN and DONE are ignored
        @(negedge clk);
        start  = 1'b1;
        a_in   = 8'h12;
        b_in   = 8'h34;
        cin_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            chk($sformatf("ign_done_c%0d", c), done, (c == W) ? 1 : 0);
            chk($sformatf("ign_busy_c%0d", c), busy, (c < W) ? 1 : 0);
            if (c >= W) begin
                chk($sformatf("ign_sum_c%0d", c), sum_out, 8'h46);
                chk($sformatf("ign_cout_c%0d", c), cout, 0);
            end
            start  = (c == 2 || c == W) ? 1'b1 : 1'b0;
            a_in   = 8'h55;
            b_in   = 8'h55;
            cin_in = 1'b0;
        end
        start = 1'b0;

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start  = 1'b1;
        a_in   = 8'hAA;
        b_in   = 8'h55;
        cin_in = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum_out, 0);
        chk("arst_cout", cout, 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        run8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Randomized back-to-back operations with start held high
        repeat (2) @(negedge clk);
        start     = 1'b1;
        a_in      = W'($urandom);
        b_in      = W'($urandom);
        cin_in    = 1'($urandom);
        e         = 0;
        next_acc  = 1;
        last_done = -1;
        ops       = 0;
        cyc       = 0;
        while (ops < 1000 && cyc < 12000) begin
            @(posedge clk);
            e++;
            cyc++;
            if (e == next_acc) begin
                o.a   = a_in;
                o.b   = b_in;
                o.cin = cin_in;
                o.acc = e;
                q.push_back(o);
                next_acc += W + 2;
            end
            @(negedge clk);
            exp_done = (q.size() > 0) && (q[0].acc + W == e);
            if (exp_done || done) chk("rand_done", done, exp_done);
            if (exp_done) begin
                o = q.pop_front();
                ref_sum = (W + 1)'(o.a) + (W + 1)'(o.b) + (W + 1)'(o.cin);
                chk($sformatf("rand_sum_%0d", ops), {cout, sum_out}, ref_sum);
                if (last_done >= 0) chk("rand_spacing", e - last_done, W + 2);
                last_done = e;
                ops++;
            end
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            cin_in = 1'($urandom);
        end
        chk("rand_op_count", ops, 1000);
        start = 1'b0;
        repeat (W + 3) @(posedge clk);

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start1 = 1'b1;
            a1     = 1'(i >> 2);
            b1     = 1'(i >> 1);
            cin1   = 1'(i);
            ref1   = 2'(i >> 2 & 1) + 2'(i >> 1 & 1) + 2'(i & 1);
            @(posedge clk);
            #1;
            start1 = 1'b0;
            a1     = ~a1;
            b1     = ~b1;
            cin1   = ~cin1;
            chk($sformatf("w1_busy_%0d", i), busy1, 1);
            @(posedge clk);
            #1;
            chk($sformatf("w1_done_%0d", i), done1, 1);
            chk($sformatf("w1_result_%0d", i), {cout1, sum1}, ref1);
            @(posedge clk);
            #1;
            chk($sformatf("w1_idle_%0d", i), {busy1, done1}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
